// File: rtl/imem_program_loader_pkg.sv
// Shared ISA constants for the program loader; the values must match the
// Controller's decode tables exactly, or loaded programs will be misread.
package imem_program_loader_pkg;

  localparam logic [3:0] MN_ADD  = 4'd0;
  localparam logic [3:0] MN_SUB  = 4'd1;
  localparam logic [3:0] MN_AND  = 4'd2;
  localparam logic [3:0] MN_OR   = 4'd3;
  localparam logic [3:0] MN_SLT  = 4'd4;
  localparam logic [3:0] MN_JR   = 4'd5;
  localparam logic [3:0] MN_ADDI = 4'd6;
  localparam logic [3:0] MN_SLTI = 4'd7;
  localparam logic [3:0] MN_LW   = 4'd8;
  localparam logic [3:0] MN_SW   = 4'd9;
  localparam logic [3:0] MN_J    = 4'd10;
  localparam logic [3:0] MN_JAL  = 4'd11;
  localparam logic [3:0] MN_BEQ  = 4'd12;
  localparam logic [3:0] MN_BNE  = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;

  // Controller-specific functs, deliberately not the standard MIPS ones
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd17;
  localparam logic [5:0] FN_OR  = 6'd7;
  localparam logic [5:0] FN_SLT = 6'd42;
  localparam logic [5:0] FN_JR  = 6'd8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [3:0]  mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_fields_t;

endpackage

// File: rtl/imem_program_loader_if.sv
// Symbolic-instruction stream in, instruction-memory write port out.
interface imem_program_loader_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_last, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, in_mnem, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_program_loader_instr_encode.sv
// Combinational packer: symbolic fields -> 32-bit Controller instruction word.
module instr_encode
  import imem_program_loader_pkg::*;
(
  input  instr_fields_t f,
  output logic [31:0]   word,
  output logic          illegal
);

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (f.mnem)
      MN_ADD:  word = enc_r(f.rs, f.rt, f.rd, FN_ADD);
      MN_SUB:  word = enc_r(f.rs, f.rt, f.rd, FN_SUB);
      MN_AND:  word = enc_r(f.rs, f.rt, f.rd, FN_AND);
      MN_OR:   word = enc_r(f.rs, f.rt, f.rd, FN_OR);
      MN_SLT:  word = enc_r(f.rs, f.rt, f.rd, FN_SLT);
      MN_JR:   word = enc_r(f.rs, 5'd0, 5'd0, FN_JR);
      MN_ADDI: word = enc_i(OP_ADDI, f.rs, f.rt, f.imm);
      MN_SLTI: word = enc_i(OP_SLTI, f.rs, f.rt, f.imm);
      MN_LW:   word = enc_i(OP_LW,   f.rs, f.rt, f.imm);
      MN_SW:   word = enc_i(OP_SW,   f.rs, f.rt, f.imm);
      MN_BEQ:  word = enc_i(OP_BEQ,  f.rs, f.rt, f.imm);
      MN_BNE:  word = enc_i(OP_BNE,  f.rs, f.rt, f.imm);
      MN_J:    word = {OP_J,   f.target};
      MN_JAL:  word = {OP_JAL, f.target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imem_program_loader.sv
// Boot-time program loader: encodes a stream of symbolic instructions and
// writes them into instruction memory, one word per two cycles at most.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = 1024
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  imem_program_loader_if.slave  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           count
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [15:0]       count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q,   err_d;
  logic              last_q,  last_d;

  instr_fields_t fields;
  logic [31:0]   enc_word;
  logic          enc_illegal;

  assign fields = '{mnem: bus.in_mnem, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                    imm: bus.in_imm, target: bus.in_target};

  instr_encode u_enc (
    .f       (fields),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          addr_d  = BASE_ADDR;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          if (enc_illegal) begin
            // Drop the word but honour in_last so the session still terminates
            err_d = 1'b1;
            if (bus.in_last) state_d = ST_DONE;
          end else begin
            wdata_d = enc_word;
            last_d  = bus.in_last;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDR_W'(4);
        count_d = count_q + 16'd1;
        if (last_q || (32'(count_q) + 32'd1 == 32'(DEPTH))) state_d = ST_DONE;
        else                                                 state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      count_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_LOAD);
  assign bus.imem_we    = (state_q == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign done           = (state_q == ST_DONE);
  assign err            = err_q;
  assign count          = count_q;

endmodule
